v_id_seq: RTL and testbench
===========================

Name: v_id_seq

Overview:
Second-generation vector decode stage with register grouping (LMUL) support. It accepts one RV32V instruction per handshake and expands it into 1..MAX_LMUL micro-ops, one per group member. Each micro-op reads the vector and scalar register files and delivers operands plus memory and writeback controls to the execute/memory stage. Downstream flow is controlled by a valid/ready handshake, and output fields are registered.

Parameters:
VREG_DW, 256, vector register / micro-op operand width
VREG_AW, 5, vector register address width
VMEM_DW, 256, vector memory data width (== VREG_DW)
VMEM_AW, 32, vector memory address width
INST_DW, 32, instruction width
REG_DW, 32, scalar register width
REG_AW, 5, scalar register address width
SEW, 32, element width; VREG_DW % SEW == 0; lanes = VREG_DW/SEW
VALUOP_DW, 5, ALU opcode width
MAX_LMUL, 8, largest register group size; power of two, 1..8

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
inst_valid_i  in  1  instruction offered
inst_ready_o  out  1  block can accept an instruction
inst_i  in  INST_DW  instruction
lmul_i  in  2  log2(LMUL) from vtype, sampled at accept
rs1_en_o / rs1_addr_o / rs1_dout_i  out/out/in  1/REG_AW/REG_DW  scalar read port (combinational data)
vs1_en_o / vs1_addr_o / vs1_dout_i  out/out/in  1/VREG_AW/VREG_DW  vector read port 1
vs2_en_o / vs2_addr_o / vs2_dout_i  out/out/in  1/VREG_AW/VREG_DW  vector read port 2 (also store data vs3)
uop_valid_o  out  1  micro-op valid
uop_ready_i  in  1  downstream accepts
uop_last_o  out  1  last micro-op of instruction
valu_opcode_o  out  VALUOP_DW  NOP=0, VADD=1, VMUL=2
operand_v1_o, operand_v2_o  out  VREG_DW  ALU operands
vmem_ren_o, vmem_wen_o  out  1  memory read/write
vmem_addr_o  out  VMEM_AW  byte address
vmem_din_o  out  VMEM_DW  store data
wb_en_o, wb_sel_o  out  1  writeback enable; sel 1 = memory, 0 = ALU
wb_addr_o  out  VREG_AW  destination register
illegal_o  out  1  one-cycle pulse: instruction rejected

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, all registered outputs are 0, uop_valid_o=0, illegal_o=0. A held instruction is discarded; a reset mid-group drops the remaining micro-ops.
- FSM IDLE:
  - inst_ready_o=1.
  - On inst_valid_i, drive rs1_en_o=1 and rs1_addr_o=inst[19:15].
  - On accept, latch inst, rs1_dout_i, and n=1<<lmul_i.
  - Legal instruction: go to BUSY with k=0.
  - Unsupported encoding, or lmul_i > log2(MAX_LMUL): pulse illegal_o the next cycle, stay IDLE, issue no micro-op.
- FSM BUSY:
  - inst_ready_o=0.
  - Read addresses are base+k; enables follow the instruction class.
  - When !uop_valid_o || uop_ready_i, load the output register from the current read data and set k++.
  - When the loaded k==n-1, set uop_last_o=1 and go to IDLE.
  - With uop_valid_o=1 and uop_ready_i=0, all outputs hold stable.
- Latency: accept at cycle T gives first uop_valid_o at T+2. Back-to-back micro-ops issue at 1/cycle under continuous ready.
- Decode (encodings per define_rv32v.v):
  - vle32: ren=1, wb_en=1, wb_sel=1, wb_addr=rd+k, addr=rs1_q + k*(VREG_DW/8).
  - vse32: wen=1, vs2 port reads rd+k, din=vs2_dout_i, same address rule, no writeback.
  - vadd/vmul .vv: v1=vs1[rs1field+k], v2=vs2[vs2field+k].
  - .vx: v1=vs2 data, v2=rs1_q[SEW-1:0] replicated lanes times.
  - .vi: v1=vs2 data, v2=sign-extended 5-bit imm to SEW, replicated.
  - ALU ops: wb_en=1, wb_sel=0, wb_addr=rd+k.
- Register addresses add modulo 2^VREG_AW. Memory address adds modulo 2^VMEM_AW.
- Each micro-op carries the operands of its own group member. ALU arithmetic is elementwise per SEW lane; lanes do not interact.

Optional Feature:
V_ID_SEQ_ALIGN_CHK_EN
- Defined: if any register base used (rd, vs2 field, and vs1 field for .vv) is not a multiple of n, the instruction is rejected with an illegal_o pulse and no micro-ops.
- Undefined: no check; addresses wrap modulo 32.

Decomposition:
- Package v_pkg: VALU_OP_NOP/VADD/VMUL, a class enum (LOAD, STORE, ALU_VV, ALU_VX, ALU_VI, ILLEGAL), and FSM state constants.
- One natural sub-module, v_dec_class: a combinational instruction classifier that outputs class, ALU op, and field bases.

Test Plan:
- LMUL=1, vadd.vv v3,v1,v2 with ready=1 -> one micro-op at T+2; opcode=1, wb_addr=3, uop_last_o=1.
- LMUL=4 (lmul_i=2), vle32 v8,(x5), x5=0x1000 -> 4 micro-ops with addr 0x1000/0x1020/0x1040/0x1060, wb_addr 8..11, wb_sel=1.
- vmul.vi v4,v4,-3, SEW=32 -> operand_v2_o = 8 lanes of 0xFFFFFFFD.
- LMUL=2, vse32: hold uop_ready_i=0 for 3 cycles after first valid -> outputs stable, inst_ready_o=0, second micro-op follows once ready rises.
- Undefined funct6 and lmul_i=3 with MAX_LMUL=4 -> illegal_o pulses 1 cycle, no uop_valid_o. With ALIGN_CHK_EN, LMUL=2 and rd=v3 -> illegal_o.
- Assert reset after the 2nd of 4 micro-ops -> uop_valid_o=0 immediately, IDLE, inst_ready_o=1 after release.

Source files
------------

// File: rtl/v_id_seq_pkg.sv
// Shared encodings, instruction classes and FSM states for the v_id_seq vector decode stage.
package v_id_seq_pkg;

    localparam logic [4:0] VALU_OP_NOP  = 5'd0;
    localparam logic [4:0] VALU_OP_VADD = 5'd1;
    localparam logic [4:0] VALU_OP_VMUL = 5'd2;

    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_OP_V     = 7'b1010111;

    localparam logic [2:0] F3_OPIVV   = 3'b000;
    localparam logic [2:0] F3_OPIVI   = 3'b011;
    localparam logic [2:0] F3_OPIVX   = 3'b100;
    localparam logic [2:0] F3_WIDTH32 = 3'b110;

    localparam logic [5:0] F6_VADD = 6'b000000;
    localparam logic [5:0] F6_VMUL = 6'b100101;

    typedef enum logic [2:0] {
        CLS_LOAD,
        CLS_STORE,
        CLS_ALU_VV,
        CLS_ALU_VX,
        CLS_ALU_VI,
        CLS_ILLEGAL
    } vclass_e;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

endpackage

// File: rtl/v_id_seq_if.sv
// Micro-op bus from the v_id_seq decode stage to the execute/memory stage.
interface v_id_seq_if #(
    parameter int unsigned VREG_DW   = 256,
    parameter int unsigned VREG_AW   = 5,
    parameter int unsigned VMEM_DW   = 256,
    parameter int unsigned VMEM_AW   = 32,
    parameter int unsigned VALUOP_DW = 5
);
    logic                 uop_valid_o;
    logic                 uop_ready_i;
    logic                 uop_last_o;
    logic [VALUOP_DW-1:0] valu_opcode_o;
    logic [VREG_DW-1:0]   operand_v1_o;
    logic [VREG_DW-1:0]   operand_v2_o;
    logic                 vmem_ren_o;
    logic                 vmem_wen_o;
    logic [VMEM_AW-1:0]   vmem_addr_o;
    logic [VMEM_DW-1:0]   vmem_din_o;
    logic                 wb_en_o;
    logic                 wb_sel_o;
    logic [VREG_AW-1:0]   wb_addr_o;

    modport master (
        output uop_valid_o, uop_last_o, valu_opcode_o, operand_v1_o, operand_v2_o,
               vmem_ren_o, vmem_wen_o, vmem_addr_o, vmem_din_o, wb_en_o, wb_sel_o, wb_addr_o,
        input  uop_ready_i
    );

    modport slave (
        input  uop_valid_o, uop_last_o, valu_opcode_o, operand_v1_o, operand_v2_o,
               vmem_ren_o, vmem_wen_o, vmem_addr_o, vmem_din_o, wb_en_o, wb_sel_o, wb_addr_o,
        output uop_ready_i
    );
endinterface

// File: rtl/v_id_seq_dec_class.sv
// Combinational RV32V classifier: instruction class, ALU op and register field bases.
module v_dec_class
    import v_id_seq_pkg::*;
(
    input  logic [31:0] inst_i,
    output vclass_e     cls_o,
    output logic [4:0]  aluop_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  vs1_o,
    output logic [4:0]  vs2_o
);
    always_comb begin
        cls_o   = CLS_ILLEGAL;
        aluop_o = VALU_OP_NOP;
        rd_o    = inst_i[11:7];
        vs1_o   = inst_i[19:15];
        vs2_o   = inst_i[24:20];
        // Only unmasked (vm=1) forms are supported.
        if (inst_i[25]) begin
            case (inst_i[6:0])
                OPC_LOAD_FP: begin
                    if (inst_i[14:12] == F3_WIDTH32 && inst_i[31:26] == 6'b0 && inst_i[24:20] == 5'b0)
                        cls_o = CLS_LOAD;
                end
                OPC_STORE_FP: begin
                    if (inst_i[14:12] == F3_WIDTH32 && inst_i[31:26] == 6'b0 && inst_i[24:20] == 5'b0)
                        cls_o = CLS_STORE;
                end
                OPC_OP_V: begin
                    case (inst_i[14:12])
                        F3_OPIVV: cls_o = CLS_ALU_VV;
                        F3_OPIVX: cls_o = CLS_ALU_VX;
                        F3_OPIVI: cls_o = CLS_ALU_VI;
                        default:  cls_o = CLS_ILLEGAL;
                    endcase
                    case (inst_i[31:26])
                        F6_VADD: aluop_o = VALU_OP_VADD;
                        F6_VMUL: aluop_o = VALU_OP_VMUL;
                        default: cls_o   = CLS_ILLEGAL;
                    endcase
                end
                default: cls_o = CLS_ILLEGAL;
            endcase
        end
    end
endmodule

// File: rtl/v_id_seq.sv
// Vector decode stage: expands one RV32V instruction into 1..MAX_LMUL registered micro-ops.
// Optional build macro V_ID_SEQ_ALIGN_CHK_EN rejects register bases not aligned to the group size.
module v_id_seq
    import v_id_seq_pkg::*;
#(
    parameter int unsigned VREG_DW   = 256,
    parameter int unsigned VREG_AW   = 5,
    parameter int unsigned VMEM_DW   = 256,
    parameter int unsigned VMEM_AW   = 32,
    parameter int unsigned INST_DW   = 32,
    parameter int unsigned REG_DW    = 32,
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned SEW       = 32,
    parameter int unsigned VALUOP_DW = 5,
    parameter int unsigned MAX_LMUL  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_valid_i,
    output logic               inst_ready_o,
    input  logic [INST_DW-1:0] inst_i,
    input  logic [1:0]         lmul_i,
    output logic               rs1_en_o,
    output logic [REG_AW-1:0]  rs1_addr_o,
    input  logic [REG_DW-1:0]  rs1_dout_i,
    output logic               vs1_en_o,
    output logic [VREG_AW-1:0] vs1_addr_o,
    input  logic [VREG_DW-1:0] vs1_dout_i,
    output logic               vs2_en_o,
    output logic [VREG_AW-1:0] vs2_addr_o,
    input  logic [VREG_DW-1:0] vs2_dout_i,
    v_id_seq_if.master         uop,
    output logic               illegal_o
);
    localparam int unsigned LANES        = VREG_DW / SEW;
    localparam int unsigned BYTES        = VREG_DW / 8;
    localparam int unsigned CNT_W        = $clog2(MAX_LMUL) + 1;
    localparam logic [1:0]  LMUL_MAX_LOG = 2'($clog2(MAX_LMUL));

    vclass_e    dec_cls;
    logic [4:0] dec_aluop, dec_rd, dec_vs1, dec_vs2;
    logic       align_ok, inst_legal;

    v_dec_class u_dec (
        .inst_i  (inst_i),
        .cls_o   (dec_cls),
        .aluop_o (dec_aluop),
        .rd_o    (dec_rd),
        .vs1_o   (dec_vs1),
        .vs2_o   (dec_vs2)
    );

`ifdef V_ID_SEQ_ALIGN_CHK_EN
    logic [4:0] grp_mask;
    assign grp_mask = 5'((32'd1 << lmul_i) - 32'd1);
    always_comb begin
        align_ok = ((dec_rd & grp_mask) == '0);
        if (dec_cls inside {CLS_ALU_VV, CLS_ALU_VX, CLS_ALU_VI})
            align_ok = align_ok && ((dec_vs2 & grp_mask) == '0);
        if (dec_cls == CLS_ALU_VV)
            align_ok = align_ok && ((dec_vs1 & grp_mask) == '0);
    end
`else
    assign align_ok = 1'b1;
`endif

    assign inst_legal = (dec_cls != CLS_ILLEGAL) && (lmul_i <= LMUL_MAX_LOG) && align_ok;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     k_q, k_d, n_q, n_d;
    vclass_e              cls_q, cls_d;
    logic [4:0]           aluop_q, aluop_d, rd_q, rd_d, vs1b_q, vs1b_d, vs2b_q, vs2b_d;
    logic [REG_DW-1:0]    rs1_q, rs1_d;
    logic                 illegal_q, illegal_d, valid_q, valid_d, last_q, last_d;
    logic [VALUOP_DW-1:0] op_q, op_d;
    logic [VREG_DW-1:0]   v1_q, v1_d, v2_q, v2_d;
    logic                 ren_q, ren_d, wen_q, wen_d, wben_q, wben_d, wbsel_q, wbsel_d;
    logic [VMEM_AW-1:0]   addr_q, addr_d;
    logic [VMEM_DW-1:0]   din_q, din_d;
    logic [VREG_AW-1:0]   wbaddr_q, wbaddr_d;

    logic [VMEM_AW-1:0]   mem_addr;
    logic [VREG_AW-1:0]   rd_k;
    logic [SEW-1:0]       imm_sext;

    assign mem_addr = VMEM_AW'(rs1_q) + VMEM_AW'(k_q) * VMEM_AW'(BYTES);
    assign rd_k     = VREG_AW'(rd_q) + VREG_AW'(k_q);
    assign imm_sext = {{(SEW-5){vs1b_q[4]}}, vs1b_q};

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        cls_d     = cls_q;
        aluop_d   = aluop_q;
        rd_d      = rd_q;
        vs1b_d    = vs1b_q;
        vs2b_d    = vs2b_q;
        rs1_d     = rs1_q;
        illegal_d = 1'b0;
        valid_d   = valid_q && !uop.uop_ready_i;
        last_d    = last_q;
        op_d      = op_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        ren_d     = ren_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        din_d     = din_q;
        wben_d    = wben_q;
        wbsel_d   = wbsel_q;
        wbaddr_d  = wbaddr_q;

        inst_ready_o = 1'b0;
        rs1_en_o     = 1'b0;
        rs1_addr_o   = REG_AW'(dec_vs1);
        vs1_en_o     = 1'b0;
        vs2_en_o     = 1'b0;
        vs1_addr_o   = VREG_AW'(vs1b_q) + VREG_AW'(k_q);
        // Stores read their data register (vs3, in the rd field) through port 2.
        vs2_addr_o   = (cls_q == CLS_STORE) ? rd_k : VREG_AW'(vs2b_q) + VREG_AW'(k_q);

        case (state_q)
            S_IDLE: begin
                inst_ready_o = 1'b1;
                rs1_en_o     = inst_valid_i;
                if (inst_valid_i) begin
                    if (inst_legal) begin
                        state_d = S_BUSY;
                        k_d     = '0;
                        n_d     = CNT_W'(1) << lmul_i;
                        cls_d   = dec_cls;
                        aluop_d = dec_aluop;
                        rd_d    = dec_rd;
                        vs1b_d  = dec_vs1;
                        vs2b_d  = dec_vs2;
                        rs1_d   = rs1_dout_i;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                vs1_en_o = (cls_q == CLS_ALU_VV);
                vs2_en_o = (cls_q != CLS_LOAD);
                if (!valid_q || uop.uop_ready_i) begin
                    valid_d  = 1'b1;
                    k_d      = k_q + CNT_W'(1);
                    last_d   = (k_q == n_q - CNT_W'(1));
                    if (last_d)
                        state_d = S_IDLE;
                    op_d     = '0;
                    v1_d     = '0;
                    v2_d     = '0;
                    ren_d    = 1'b0;
                    wen_d    = 1'b0;
                    addr_d   = '0;
                    din_d    = '0;
                    wben_d   = 1'b0;
                    wbsel_d  = 1'b0;
                    wbaddr_d = '0;
                    case (cls_q)
                        CLS_LOAD: begin
                            ren_d    = 1'b1;
                            addr_d   = mem_addr;
                            wben_d   = 1'b1;
                            wbsel_d  = 1'b1;
                            wbaddr_d = rd_k;
                        end
                        CLS_STORE: begin
                            wen_d  = 1'b1;
                            addr_d = mem_addr;
                            din_d  = VMEM_DW'(vs2_dout_i);
                        end
                        CLS_ALU_VV, CLS_ALU_VX, CLS_ALU_VI: begin
                            op_d     = VALUOP_DW'(aluop_q);
                            wben_d   = 1'b1;
                            wbaddr_d = rd_k;
                            if (cls_q == CLS_ALU_VV) begin
                                v1_d = vs1_dout_i;
                                v2_d = vs2_dout_i;
                            end else begin
                                v1_d = vs2_dout_i;
                                v2_d = (cls_q == CLS_ALU_VX) ? VREG_DW'({LANES{rs1_q[SEW-1:0]}})
                                                             : VREG_DW'({LANES{imm_sext}});
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            n_q       <= '0;
            cls_q     <= CLS_LOAD;
            aluop_q   <= '0;
            rd_q      <= '0;
            vs1b_q    <= '0;
            vs2b_q    <= '0;
            rs1_q     <= '0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            op_q      <= '0;
            v1_q      <= '0;
            v2_q      <= '0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            wben_q    <= 1'b0;
            wbsel_q   <= 1'b0;
            wbaddr_q  <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            n_q       <= n_d;
            cls_q     <= cls_d;
            aluop_q   <= aluop_d;
            rd_q      <= rd_d;
            vs1b_q    <= vs1b_d;
            vs2b_q    <= vs2b_d;
            rs1_q     <= rs1_d;
            illegal_q <= illegal_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            op_q      <= op_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            ren_q     <= ren_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            wben_q    <= wben_d;
            wbsel_q   <= wbsel_d;
            wbaddr_q  <= wbaddr_d;
        end
    end

    assign illegal_o         = illegal_q;
    assign uop.uop_valid_o   = valid_q;
    assign uop.uop_last_o    = last_q;
    assign uop.valu_opcode_o = op_q;
    assign uop.operand_v1_o  = v1_q;
    assign uop.operand_v2_o  = v2_q;
    assign uop.vmem_ren_o    = ren_q;
    assign uop.vmem_wen_o    = wen_q;
    assign uop.vmem_addr_o   = addr_q;
    assign uop.vmem_din_o    = din_q;
    assign uop.wb_en_o       = wben_q;
    assign uop.wb_sel_o      = wbsel_q;
    assign uop.wb_addr_o     = wbaddr_q;
endmodule

// File: tb/tb_v_id_seq.sv
// Directed self-checking bench for v_id_seq (built with MAX_LMUL=4).
module tb_v_id_seq;
    logic         clk = 1'b0;
    logic         rst;
    logic         inst_valid_i, inst_ready_o;
    logic [31:0]  inst_i;
    logic [1:0]   lmul_i;
    logic         rs1_en_o, vs1_en_o, vs2_en_o, illegal_o;
    logic [4:0]   rs1_addr_o, vs1_addr_o, vs2_addr_o;
    logic [31:0]  rs1_dout_i;
    logic [255:0] vs1_dout_i, vs2_dout_i;
    logic [31:0]  xreg [32];
    logic [15:0]  ctrl;
    int unsigned  nvec = 0;
    int unsigned  nerr = 0;

    always #5 clk = ~clk;

    v_id_seq_if u_if ();

    v_id_seq #(.MAX_LMUL(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_valid_i (inst_valid_i),
        .inst_ready_o (inst_ready_o),
        .inst_i       (inst_i),
        .lmul_i       (lmul_i),
        .rs1_en_o     (rs1_en_o),
        .rs1_addr_o   (rs1_addr_o),
        .rs1_dout_i   (rs1_dout_i),
        .vs1_en_o     (vs1_en_o),
        .vs1_addr_o   (vs1_addr_o),
        .vs1_dout_i   (vs1_dout_i),
        .vs2_en_o     (vs2_en_o),
        .vs2_addr_o   (vs2_addr_o),
        .vs2_dout_i   (vs2_dout_i),
        .uop          (u_if),
        .illegal_o    (illegal_o)
    );

    // Register contents: lane l of vreg r holds 0xA000_0000 | r<<8 | l.
    function automatic logic [255:0] vpat(input logic [4:0] r);
        logic [255:0] v;
        for (int l = 0; l < 8; l++)
            v[l*32 +: 32] = 32'hA000_0000 | (32'(r) << 8) | 32'(l);
        return v;
    endfunction

    function automatic logic [31:0] enc_opv(input logic [5:0] f6, input logic [4:0] vs2,
                                            input logic [4:0] vs1, input logic [2:0] f3,
                                            input logic [4:0] vd);
        return {f6, 1'b1, vs2, vs1, f3, vd, 7'b1010111};
    endfunction

    function automatic logic [31:0] enc_mem(input logic store, input logic [4:0] rs1, input logic [4:0] vd);
        return {6'b0, 1'b1, 5'b0, rs1, 3'b110, vd, (store ? 7'b0100111 : 7'b0000111)};
    endfunction

    assign rs1_dout_i = rs1_en_o ? xreg[rs1_addr_o] : '0;
    assign vs1_dout_i = vs1_en_o ? vpat(vs1_addr_o) : '0;
    assign vs2_dout_i = vs2_en_o ? vpat(vs2_addr_o) : '0;
    assign ctrl = {u_if.uop_valid_o, u_if.uop_last_o, u_if.valu_opcode_o, u_if.vmem_ren_o,
                   u_if.vmem_wen_o, u_if.wb_en_o, u_if.wb_sel_o, u_if.wb_addr_o};

    task automatic issue(input logic [31:0] ins, input logic [1:0] lm);
        inst_i       = ins;
        lmul_i       = lm;
        inst_valid_i = 1'b1;
        @(posedge clk); #1;
        inst_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; inst_valid_i = 1'b0; inst_i = '0; lmul_i = '0; u_if.uop_ready_i = 1'b1;
        for (int i = 0; i < 32; i++) xreg[i] = 32'h0;
        repeat (2) @(posedge clk); #1;
        nvec++;
        if ({ctrl, illegal_o, inst_ready_o, u_if.vmem_addr_o} !== {16'h0, 1'b0, 1'b1, 32'h0}) begin
            nerr++;
            $display("FAIL reset_state: got %h expected %h",
                     {ctrl, illegal_o, inst_ready_o, u_if.vmem_addr_o}, {16'h0, 1'b0, 1'b1, 32'h0});
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vadd_vv;
        issue(enc_opv(6'b000000, 5'd1, 5'd2, 3'b000, 5'd3), 2'd0);
        nvec++;
        if (u_if.uop_valid_o !== 1'b0) begin
            nerr++; $display("FAIL vv_latency_t1: got valid=%b expected 0", u_if.uop_valid_o);
        end
        @(posedge clk); #1;
        nvec++;
        if (ctrl !== {2'b11, 5'd1, 4'b0010, 5'd3}) begin
            nerr++; $display("FAIL vv_ctrl: got %h expected %h", ctrl, {2'b11, 5'd1, 4'b0010, 5'd3});
        end
        nvec++;
        if ({u_if.operand_v1_o, u_if.operand_v2_o} !== {vpat(5'd2), vpat(5'd1)}) begin
            nerr++; $display("FAIL vv_operands: got %h %h expected %h %h",
                             u_if.operand_v1_o, u_if.operand_v2_o, vpat(5'd2), vpat(5'd1));
        end
        @(posedge clk); #1;
        nvec++;
        if (u_if.uop_valid_o !== 1'b0) begin
            nerr++; $display("FAIL vv_drain: got valid=%b expected 0", u_if.uop_valid_o);
        end
    endtask

    task automatic test_vle_lmul4;
        xreg[5] = 32'h0000_1000;
        issue(enc_mem(1'b0, 5'd5, 5'd8), 2'd2);
        nvec++;
        if (inst_ready_o !== 1'b0) begin
            nerr++; $display("FAIL vle_busy_ready: got %b expected 0", inst_ready_o);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            nvec++;
            if (ctrl !== {1'b1, (k == 3), 5'd0, 4'b1011, 5'(8 + k)}) begin
                nerr++; $display("FAIL vle_ctrl k=%0d: got %h expected %h", k, ctrl,
                                 {1'b1, (k == 3), 5'd0, 4'b1011, 5'(8 + k)});
            end
            nvec++;
            if (u_if.vmem_addr_o !== 32'(32'h1000 + 32 * k)) begin
                nerr++; $display("FAIL vle_addr k=%0d: got %h expected %h", k, u_if.vmem_addr_o,
                                 32'(32'h1000 + 32 * k));
            end
        end
        @(posedge clk); #1;
        nvec++;
        if ({u_if.uop_valid_o, inst_ready_o} !== 2'b01) begin
            nerr++; $display("FAIL vle_drain: got valid,ready=%b expected 01", {u_if.uop_valid_o, inst_ready_o});
        end
    endtask

    task automatic test_vmul_vi;
        issue(enc_opv(6'b100101, 5'd4, 5'b11101, 3'b011, 5'd4), 2'd0);
        @(posedge clk); #1;
        nvec++;
        if (ctrl !== {2'b11, 5'd2, 4'b0010, 5'd4}) begin
            nerr++; $display("FAIL vi_ctrl: got %h expected %h", ctrl, {2'b11, 5'd2, 4'b0010, 5'd4});
        end
        nvec++;
        if ({u_if.operand_v1_o, u_if.operand_v2_o} !== {vpat(5'd4), {8{32'hFFFF_FFFD}}}) begin
            nerr++; $display("FAIL vi_operands: got %h %h expected %h %h", u_if.operand_v1_o,
                             u_if.operand_v2_o, vpat(5'd4), {8{32'hFFFF_FFFD}});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_vx_wrap;
        xreg[7] = 32'h1234_5678;
        issue(enc_opv(6'b000000, 5'd31, 5'd7, 3'b100, 5'd31), 2'd1);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            nvec++;
            if (ctrl !== {1'b1, (k == 1), 5'd1, 4'b0010, 5'(31 + k)}) begin
                nerr++; $display("FAIL vx_ctrl k=%0d: got %h expected %h", k, ctrl,
                                 {1'b1, (k == 1), 5'd1, 4'b0010, 5'(31 + k)});
            end
            nvec++;
            if ({u_if.operand_v1_o, u_if.operand_v2_o} !== {vpat(5'(31 + k)), {8{32'h1234_5678}}}) begin
                nerr++; $display("FAIL vx_operands k=%0d: got %h %h expected %h %h", k, u_if.operand_v1_o,
                                 u_if.operand_v2_o, vpat(5'(31 + k)), {8{32'h1234_5678}});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_vse_stall;
        xreg[6] = 32'hFFFF_FFF0;
        u_if.uop_ready_i = 1'b0;
        issue(enc_mem(1'b1, 5'd6, 5'd2), 2'd1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            nvec++;
            if ({ctrl, inst_ready_o, u_if.vmem_addr_o} !== {2'b10, 5'd0, 4'b0100, 5'd0, 1'b0, 32'hFFFF_FFF0}) begin
                nerr++; $display("FAIL vse_hold c=%0d: got %h expected %h", c, {ctrl, inst_ready_o, u_if.vmem_addr_o},
                                 {2'b10, 5'd0, 4'b0100, 5'd0, 1'b0, 32'hFFFF_FFF0});
            end
            nvec++;
            if (u_if.vmem_din_o !== vpat(5'd2)) begin
                nerr++; $display("FAIL vse_din0 c=%0d: got %h expected %h", c, u_if.vmem_din_o, vpat(5'd2));
            end
        end
        u_if.uop_ready_i = 1'b1;
        @(posedge clk); #1;
        nvec++;
        if ({ctrl, u_if.vmem_addr_o, u_if.vmem_din_o} !== {2'b11, 5'd0, 4'b0100, 5'd0, 32'h0000_0010, vpat(5'd3)}) begin
            nerr++; $display("FAIL vse_second: got %h expected %h", {ctrl, u_if.vmem_addr_o, u_if.vmem_din_o},
                             {2'b11, 5'd0, 4'b0100, 5'd0, 32'h0000_0010, vpat(5'd3)});
        end
        @(posedge clk); #1;
        nvec++;
        if (u_if.uop_valid_o !== 1'b0) begin
            nerr++; $display("FAIL vse_drain: got valid=%b expected 0", u_if.uop_valid_o);
        end
    endtask

    task automatic test_illegal;
        logic [31:0] ins [3];
        logic [1:0]  lm  [3];
        int          cnt;
        ins[0] = enc_opv(6'b111111, 5'd1, 5'd2, 3'b000, 5'd3); lm[0] = 2'd0;
        ins[1] = enc_opv(6'b000000, 5'd1, 5'd2, 3'b000, 5'd3); lm[1] = 2'd3;
        ins[2] = enc_opv(6'b000000, 5'd2, 5'd4, 3'b000, 5'd3); lm[2] = 2'd1;
`ifdef V_ID_SEQ_ALIGN_CHK_EN
        cnt = 3;
`else
        cnt = 2;
`endif
        for (int t = 0; t < cnt; t++) begin
            issue(ins[t], lm[t]);
            nvec++;
            if ({illegal_o, u_if.uop_valid_o} !== 2'b10) begin
                nerr++; $display("FAIL illegal_pulse t=%0d: got ill,valid=%b expected 10", t, {illegal_o, u_if.uop_valid_o});
            end
            @(posedge clk); #1;
            nvec++;
            if ({illegal_o, u_if.uop_valid_o, inst_ready_o} !== 3'b001) begin
                nerr++; $display("FAIL illegal_end t=%0d: got ill,valid,ready=%b expected 001", t,
                                 {illegal_o, u_if.uop_valid_o, inst_ready_o});
            end
        end
    endtask

    task automatic test_reset_mid_group;
        xreg[5] = 32'h0000_1000;
        issue(enc_mem(1'b0, 5'd5, 5'd8), 2'd2);
        repeat (2) @(posedge clk); #1;
        nvec++;
        if ({u_if.uop_valid_o, u_if.wb_addr_o} !== {1'b1, 5'd9}) begin
            nerr++; $display("FAIL mid_second_uop: got %h expected %h", {u_if.uop_valid_o, u_if.wb_addr_o}, {1'b1, 5'd9});
        end
        rst = 1'b0;
        #1;
        nvec++;
        if ({u_if.uop_valid_o, inst_ready_o, illegal_o} !== 3'b010) begin
            nerr++; $display("FAIL mid_reset_async: got valid,ready,ill=%b expected 010",
                             {u_if.uop_valid_o, inst_ready_o, illegal_o});
        end
        #2 rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            nvec++;
            if ({u_if.uop_valid_o, inst_ready_o} !== 2'b01) begin
                nerr++; $display("FAIL mid_after_release c=%0d: got valid,ready=%b expected 01", c,
                                 {u_if.uop_valid_o, inst_ready_o});
            end
        end
    endtask

    initial begin
        test_reset();
        test_vadd_vv();
        test_vle_lmul4();
        test_vmul_vi();
`ifndef V_ID_SEQ_ALIGN_CHK_EN
        test_vx_wrap();
`endif
        test_vse_stall();
        test_illegal();
        test_reset_mid_group();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
